// File: rtl/i2c_bridge_pkg.sv
// Shared definitions for the I2C register bridge: FSM state encoding and
// the position of the R/W flag inside the address byte.
package i2c_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_PTR  = 3'd2,
    ST_DATA = 3'd3,
    ST_RD   = 3'd4
  } state_t;

  // R/W flag position in byte0 (1 = read request)
  localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_bridge_edge.sv
// START/STOP detector for the I2C slave ready line. in_ready is registered
// once and compared with its current value: a falling edge is START, a
// rising edge is STOP. Pulses are valid in the cycle the edge is seen.
module i2c_bridge_edge (
  input  logic clk,
  input  logic n_rst,
  input  logic in_ready,
  output logic start_p,
  output logic stop_p
);

  logic ready_q;

  // Delayed copy of in_ready; resets to idle-bus level so no false START
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ready_q <= 1'b1;
    else        ready_q <= in_ready;
  end

  assign start_p = ready_q & ~in_ready;
  assign stop_p  = ~ready_q & in_ready;

endmodule

// File: rtl/i2c_reg_bridge.sv
// I2C byte-stream to register-bank bridge.
// Frame: byte0 = device address + R/W, byte1 = register pointer,
// bytes2..N = data written at the pointer, which auto-increments and wraps
// at 2**ADDR_W. Writes to pointers >= NUM_REGS are dropped and set oob_err.
//
// Byte interface: in_data is only meaningful in a cycle where in_ena=1;
// each such cycle delivers exactly one byte, there is no backpressure.
// in_ready=1 means bus idle; its falling edge opens a frame, rising edge
// closes it.
//
// Optional macro I2C_BRIDGE_SHADOW_COMMIT_EN: data bytes land in a shadow
// bank and are copied to regs_flat in one cycle after STOP. Without it,
// writes update regs_flat directly.
module i2c_reg_bridge
  import i2c_bridge_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter int          ADDR_W   = 8,
  parameter logic [7:0]  RST_VAL  = 8'h00
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [7:0]            in_data,
  input  logic                  in_ena,
  input  logic                  in_ready,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic                  rd_req,
  output logic                  oob_err,
  output logic                  busy,
  output state_t                dbg_state
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              start_p;
  logic              stop_p;
  logic              data_byte;
  logic              in_range;
  logic              wr_acc;
  logic [7:0]        regs [NUM_REGS];

  i2c_bridge_edge u_edge (
    .clk      (clk),
    .n_rst    (n_rst),
    .in_ready (in_ready),
    .start_p  (start_p),
    .stop_p   (stop_p)
  );

  assign data_byte = (state == ST_DATA) && in_ena;
  assign in_range  = (32'(ptr) < NUM_REGS);
  assign wr_acc    = data_byte && in_range;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Frame FSM with pointer, write strobe, read request and error flag.
  // A byte arriving with STOP is processed, then the frame closes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
      rd_req  <= 1'b0;
      oob_err <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      rd_req <= 1'b0;
      if (data_byte) begin
        ptr <= ptr + ADDR_W'(1);
        if (in_range) begin
          wr_stb  <= 1'b1;
          wr_addr <= ptr;
          wr_data <= in_data;
        end else begin
          oob_err <= 1'b1;
        end
      end
      if ((state == ST_PTR) && in_ena) ptr <= in_data[ADDR_W-1:0];
      if ((state == ST_ADDR) && in_ena && in_data[RW_BIT]) rd_req <= 1'b1;

      if (stop_p) begin
        state <= ST_IDLE;
      end else if (start_p) begin
        state   <= ST_ADDR;
        oob_err <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_ADDR: if (in_ena) state <= in_data[RW_BIT] ? ST_RD : ST_PTR;
          ST_PTR:  if (in_ena) state <= ST_DATA;
          ST_DATA: state <= ST_DATA;
          ST_RD:   state <= ST_RD;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef I2C_BRIDGE_SHADOW_COMMIT_EN
  logic [7:0] shadow [NUM_REGS];
  logic       sh_vld [NUM_REGS];
  logic       commit_pend;

  // Shadow bank: collect frame data, copy to live bank one cycle after a
  // STOP. A START in that same cycle means the bus restarted before the
  // frame was committed, so the shadow is discarded instead.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      commit_pend <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k]   <= RST_VAL;
        shadow[k] <= RST_VAL;
        sh_vld[k] <= 1'b0;
      end
    end else begin
      commit_pend <= stop_p && (state != ST_IDLE);
      for (int k = 0; k < NUM_REGS; k++) begin
        if (commit_pend && !start_p && sh_vld[k]) regs[k] <= shadow[k];
        if (wr_acc && (32'(ptr) == k)) begin
          shadow[k] <= in_data;
          sh_vld[k] <= 1'b1;
        end
        if (commit_pend || start_p) sh_vld[k] <= 1'b0;
      end
    end
  end
`else
  // Live bank: accepted data bytes land directly
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RST_VAL;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_acc && (32'(ptr) == k)) regs[k] <= in_data;
      end
    end
  end
`endif

  // Flatten the bank, reg k at [8k+7:8k]
  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_flat[8*k +: 8] = regs[k];
  end

endmodule
